// File: rtl/refill_arbiter.sv
// Round-robin arbiter that shares one AXI burst-read master between the
// icache and dcache line-refill engines and returns beats to the owner.
module refill_arbiter #(
  parameter int unsigned BEATS   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req,
  input  logic [63:0] ic_addr,
  output logic        ic_gnt,
  input  logic        dc_req,
  input  logic [63:0] dc_addr,
  output logic        dc_gnt,
  output logic [63:0] beat_data,
  output logic [2:0]  beat_idx,
  output logic        ic_beat_valid,
  output logic        dc_beat_valid,
  output logic        ic_done,
  output logic        dc_done,
  output logic        err,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rlast,
  input  logic        mem_rerr
);

  localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [63:0] LINE_MASK = ~64'(BEATS * 8 - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA, DONE} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [TW-1:0]  tmo, tmo_n;
  logic           rr_last, rr_last_n;   // 1: dcache owned the port last
  logic           own_dc, own_dc_n;
  logic           err_flag, err_flag_n;
  logic           fin, fin_n;           // final beat forwarded, done follows
  logic           ic_gnt_n, dc_gnt_n, mem_req_n, err_n;
  logic           ic_bv_n, dc_bv_n, ic_done_n, dc_done_n;
  logic [63:0]    mem_addr_n, beat_data_n;
  logic [2:0]     beat_idx_n;
  logic           pick_dc_c, last_c, tmo_hit_c;

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    tmo_n       = tmo;
    rr_last_n   = rr_last;
    own_dc_n    = own_dc;
    err_flag_n  = err_flag;
    fin_n       = fin;
    ic_gnt_n    = ic_gnt;
    dc_gnt_n    = dc_gnt;
    mem_req_n   = mem_req;
    mem_addr_n  = mem_addr;
    beat_data_n = '0;
    beat_idx_n  = '0;
    ic_bv_n     = 1'b0;
    dc_bv_n     = 1'b0;
    ic_done_n   = 1'b0;
    dc_done_n   = 1'b0;
    err_n       = 1'b0;
    pick_dc_c   = dc_req && (!ic_req || !rr_last);
    last_c      = (cnt == CW'(BEATS - 1));
    tmo_hit_c   = (tmo == TW'(TIMEOUT - 1));

    case (state)
      IDLE: begin
        ic_gnt_n   = 1'b0;
        dc_gnt_n   = 1'b0;
        mem_req_n  = 1'b0;
        mem_addr_n = '0;
        if (ic_req || dc_req) begin
          own_dc_n   = pick_dc_c;
          ic_gnt_n   = !pick_dc_c;
          dc_gnt_n   = pick_dc_c;
          mem_req_n  = 1'b1;
          mem_addr_n = (pick_dc_c ? dc_addr : ic_addr) & LINE_MASK;
          tmo_n      = '0;
          err_flag_n = 1'b0;
          fin_n      = 1'b0;
          state_n    = ISSUE;
        end
      end

      ISSUE: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          cnt_n     = '0;
          tmo_n     = '0;
          state_n   = DATA;
        end else if (tmo_hit_c) begin
          mem_req_n = 1'b0;
          ic_done_n = !own_dc;
          dc_done_n = own_dc;
          err_n     = 1'b1;
          state_n   = DONE;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end

      DATA: begin
        if (fin) begin
          ic_done_n = !own_dc;
          dc_done_n = own_dc;
          err_n     = err_flag;
          state_n   = DONE;
        end else if (mem_rvalid) begin
          beat_data_n = mem_rdata;
          beat_idx_n  = 3'(cnt);
          ic_bv_n     = !own_dc;
          dc_bv_n     = own_dc;
          cnt_n       = cnt + CW'(1);
          tmo_n       = '0;
          // rlast must coincide exactly with the final beat
          if (mem_rerr || (mem_rlast != last_c)) err_flag_n = 1'b1;
          if (last_c || mem_rlast) fin_n = 1'b1;
        end else if (tmo_hit_c) begin
          ic_done_n = !own_dc;
          dc_done_n = own_dc;
          err_n     = 1'b1;
          state_n   = DONE;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end

      DONE: begin
        rr_last_n  = own_dc;
        err_flag_n = 1'b0;
        fin_n      = 1'b0;
        ic_gnt_n   = 1'b0;
        dc_gnt_n   = 1'b0;
        mem_req_n  = 1'b0;
        mem_addr_n = '0;
        state_n    = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      tmo           <= '0;
      rr_last       <= 1'b1;
      own_dc        <= 1'b0;
      err_flag      <= 1'b0;
      fin           <= 1'b0;
      ic_gnt        <= 1'b0;
      dc_gnt        <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      beat_data     <= '0;
      beat_idx      <= '0;
      ic_beat_valid <= 1'b0;
      dc_beat_valid <= 1'b0;
      ic_done       <= 1'b0;
      dc_done       <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      tmo           <= tmo_n;
      rr_last       <= rr_last_n;
      own_dc        <= own_dc_n;
      err_flag      <= err_flag_n;
      fin           <= fin_n;
      ic_gnt        <= ic_gnt_n;
      dc_gnt        <= dc_gnt_n;
      mem_req       <= mem_req_n;
      mem_addr      <= mem_addr_n;
      beat_data     <= beat_data_n;
      beat_idx      <= beat_idx_n;
      ic_beat_valid <= ic_bv_n;
      dc_beat_valid <= dc_bv_n;
      ic_done       <= ic_done_n;
      dc_done       <= dc_done_n;
      err           <= err_n;
    end
  end

endmodule
